// File: rtl/data_ram_pkg.sv
// Shared encodings and helpers for the data RAM controller.
// Parity support is compiled in with DATA_RAM_PARITY_EN.
package data_ram_pkg;

  localparam logic [1:0] OP_READ  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_ADD   = 2'b10;
  localparam logic [1:0] OP_SWAP  = 2'b11;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RMW  = 1'b1
  } state_t;

  // Widest data word the parity helper accepts; callers zero-extend.
  localparam int unsigned PARITY_MAX_W = 64;

  // Even parity: the returned bit makes the total count of ones even.
  function automatic logic parity_of(input logic [PARITY_MAX_W-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/data_ram_array.sv
// Single-port storage: synchronous write, registered synchronous read,
// no reset, so it maps onto block RAM.
module data_ram_array #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DEPTH  = 1024
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WIDTH-1:0]  wdata,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // The read register holds its value on writes and idle cycles.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem[addr] <= wdata;
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/data_ram_ctrl.sv
// Data RAM controller: valid/ready requests, READ/WRITE/ADD/SWAP, range check.
// Define DATA_RAM_PARITY_EN for per-word even parity and the err_inject port.
module data_ram_ctrl
  import data_ram_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DEPTH  = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_carry,
  output logic              rsp_err
`ifdef DATA_RAM_PARITY_EN
  ,
  input  logic              err_inject
`endif
);

`ifdef DATA_RAM_PARITY_EN
  localparam int unsigned MEM_W = DATA_W + 1;
`else
  localparam int unsigned MEM_W = DATA_W;
`endif
  localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W+1)'(DEPTH);

  state_t            state;
  logic [ADDR_W-1:0] rmw_addr;
  logic              rmw_is_add;
  logic [DATA_W-1:0] rmw_operand;

  logic              rsp_from_arr;
  logic [DATA_W-1:0] rsp_data_q;
  logic              rsp_err_q;

  logic              accept;
  logic              in_range;
  logic              arr_en;
  logic              arr_we;
  logic [ADDR_W-1:0] arr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [MEM_W-1:0]  arr_wdata;
  logic [MEM_W-1:0]  arr_rdata;
  logic [DATA_W-1:0] old_data;
  logic [DATA_W:0]   sum;
  logic [DATA_W-1:0] wb_data;
  logic              par_bad;

  assign req_ready = (state == ST_IDLE);
  assign accept    = req_valid && req_ready && !rst;
  assign in_range  = ({1'b0, req_addr} < DEPTH_LIM);

  // In RMW the array read register still holds the old value fetched at accept.
  assign old_data  = arr_rdata[DATA_W-1:0];
  assign sum       = {1'b0, old_data} + {1'b0, rmw_operand};
  assign wb_data   = rmw_is_add ? sum[DATA_W-1:0] : rmw_operand;

`ifdef DATA_RAM_PARITY_EN
  logic flip;
  assign par_bad   = parity_of(PARITY_MAX_W'(old_data)) != arr_rdata[DATA_W];
  assign arr_wdata = {parity_of(PARITY_MAX_W'(wr_data)) ^ flip, wr_data};
`else
  assign par_bad   = 1'b0;
  assign arr_wdata = wr_data;
`endif

  always_comb begin
    arr_en   = 1'b0;
    arr_we   = 1'b0;
    arr_addr = req_addr;
    wr_data  = req_wdata;
`ifdef DATA_RAM_PARITY_EN
    flip     = 1'b0;
`endif
    if (!rst) begin
      if (state == ST_RMW) begin
        arr_en   = 1'b1;
        arr_we   = 1'b1;
        arr_addr = rmw_addr;
        wr_data  = wb_data;
      end else if (accept && in_range) begin
        arr_en = 1'b1;
        arr_we = (req_op == OP_WRITE);
`ifdef DATA_RAM_PARITY_EN
        flip   = err_inject && (req_op == OP_WRITE);
`endif
      end
    end
  end

  data_ram_array #(
    .WIDTH  (MEM_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_array (
    .clk   (clk),
    .en    (arr_en),
    .we    (arr_we),
    .addr  (arr_addr),
    .wdata (arr_wdata),
    .rdata (arr_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      rsp_valid    <= 1'b0;
      rsp_from_arr <= 1'b0;
      rsp_data_q   <= '0;
      rsp_carry    <= 1'b0;
      rsp_err_q    <= 1'b0;
    end else begin
      rsp_valid    <= 1'b0;
      rsp_from_arr <= 1'b0;
      rsp_data_q   <= '0;
      rsp_carry    <= 1'b0;
      rsp_err_q    <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            if (!in_range) begin
              rsp_valid <= 1'b1;
              rsp_err_q <= 1'b1;
            end else if (req_op == OP_ADD || req_op == OP_SWAP) begin
              state       <= ST_RMW;
              rmw_addr    <= req_addr;
              rmw_is_add  <= (req_op == OP_ADD);
              rmw_operand <= req_wdata;
            end else if (req_op == OP_WRITE) begin
              rsp_valid  <= 1'b1;
              rsp_data_q <= req_wdata;
            end else begin
              rsp_valid    <= 1'b1;
              rsp_from_arr <= 1'b1;
            end
          end
        end
        ST_RMW: begin
          state      <= ST_IDLE;
          rsp_valid  <= 1'b1;
          rsp_data_q <= old_data;
          rsp_carry  <= rmw_is_add && sum[DATA_W];
          rsp_err_q  <= par_bad;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // READ data comes straight from the array's output register.
  assign rsp_rdata = rsp_from_arr ? old_data : rsp_data_q;
  assign rsp_err   = rsp_err_q | (rsp_from_arr & par_bad);

endmodule
